i2c_txn_arbiter: RTL

- Shares one I2C read/write engine (StartW/StartR in, donew/doner out) between N requesters, e.g. the door sensor poller and the measurement controller.
- Arbitrates round-robin and latches the winner's transaction fields.
- Issues one start pulse to the engine, waits for the matching done or a timeout, then returns ack or err plus read data to the winner.

---
 rtl/i2c_txn_arbiter_if.sv | 49 ++++
 rtl/i2c_txn_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_txn_arbiter_if
//  Description : Bundle of the requester-side and engine-side signals of the
//                I2C transaction arbiter.
//                Requester side : req, req_rw, req_addr, req_reg, req_wdata in;
//                                 gnt, ack, err, rdata, busy out.
//                Engine side    : StartW, StartR, eng_addr, eng_reg,
//                                 eng_wdata out; donew, doner, eng_rdata in.
//                master = arbiter view, slave = requesters/engine view.
//  Revision    : 1.0  initial release
// ============================================================================
interface i2c_txn_arbiter_if #(
  parameter int N = 2
) ();
  logic [N-1:0]   req;
  logic [N-1:0]   req_rw;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_reg;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [N-1:0]   err;
  logic [7:0]     rdata;
  logic           busy;
  logic           StartW;
  logic           StartR;
  logic [6:0]     eng_addr;
  logic [7:0]     eng_reg;
  logic [7:0]     eng_wdata;
  logic           donew;
  logic           doner;
  logic [7:0]     eng_rdata;

  modport master (
    input  req, req_rw, req_addr, req_reg, req_wdata,
    input  donew, doner, eng_rdata,
    output gnt, ack, err, rdata, busy,
    output StartW, StartR, eng_addr, eng_reg, eng_wdata
  );

  modport slave (
    output req, req_rw, req_addr, req_reg, req_wdata,
    output donew, doner, eng_rdata,
    input  gnt, ack, err, rdata, busy,
    input  StartW, StartR, eng_addr, eng_reg, eng_wdata
  );
endinterface
`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_txn_arbiter
//  Description : Round-robin sharing of one I2C read/write engine between N
//                requesters. Latches the winner's fields, issues one start
//                pulse, waits for the matching done (or timeout) and returns
//                ack/err plus read data to the winner.
//  Ports       : mclk   - system clock, rising edge
//                resetG - asynchronous active-low reset
//                bus    - i2c_txn_arbiter_if.master (requester + engine side)
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_txn_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 4096,
  parameter int TW      = 13
) (
  input  logic                 mclk,
  input  logic                 resetG,
  i2c_txn_arbiter_if.master    bus
);

  localparam int WW = (N > 2) ? 2 : 1;       // winner index width
  localparam int PW = $clog2(2 * N);         // index width into doubled req
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT     = 3'd3,
    S_RESP_OK  = 3'd4,
    S_RESP_ERR = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [WW-1:0]   r_last, r_win, w_pick;
  logic            w_any;
  logic [PW-1:0]   w_pos;
  logic [2*N-1:0]  w_req2;
  logic [N-1:0]    w_win_oh;
  logic            r_rw;
  logic [TW-1:0]   r_cnt;
  logic [6:0]      r_eng_addr;
  logic [7:0]      r_eng_reg, r_eng_wdata, r_rdata;
  logic            w_sel_rw;
  logic [6:0]      w_sel_addr;
  logic [7:0]      w_sel_reg, w_sel_wdata;
  logic            w_done;

  // Doubling the request vector lets the scan last+1 .. last+N run without
  // a modulo; the position is folded back into 0..N-1 afterwards.
  assign w_req2 = {bus.req, bus.req};

  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last;
    w_pos  = '0;
    for (int i = 1; i <= N; i++) begin
      w_pos = PW'(r_last) + PW'(i);
      if (!w_any && w_req2[w_pos]) begin
        w_any  = 1'b1;
        w_pick = (w_pos >= PW'(N)) ? WW'(w_pos - PW'(N)) : WW'(w_pos);
      end
    end
  end

  // Winner field select and one-hot decode
  always_comb begin
    w_sel_rw    = 1'b0;
    w_sel_addr  = '0;
    w_sel_reg   = '0;
    w_sel_wdata = '0;
    w_win_oh    = '0;
    for (int i = 0; i < N; i++) begin
      if (r_win == WW'(i)) begin
        w_sel_rw    = bus.req_rw[i];
        w_sel_addr  = bus.req_addr[7*i +: 7];
        w_sel_reg   = bus.req_reg[8*i +: 8];
        w_sel_wdata = bus.req_wdata[8*i +: 8];
        w_win_oh[i] = 1'b1;
      end
    end
  end

  // Only the done that matches the latched direction counts
  assign w_done = r_rw ? bus.doner : bus.donew;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_any) w_state_nxt = S_GRANT;
      S_GRANT:    w_state_nxt = S_ISSUE;
      S_ISSUE:    w_state_nxt = S_WAIT;
      // done is tested first so it wins over a simultaneous expiry
      S_WAIT: begin
        if (w_done)                    w_state_nxt = S_RESP_OK;
        else if (r_cnt == c_tmo_last)  w_state_nxt = S_RESP_ERR;
      end
      S_RESP_OK:  w_state_nxt = S_IDLE;
      S_RESP_ERR: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge resetG) begin
    if (!resetG) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // The counter is cleared on entry to ISSUE, so ISSUE is count 0 and the
  // k-th cycle after ISSUE holds count k; expiry at TIMEOUT-1 therefore puts
  // RESP_ERR exactly TIMEOUT cycles after the start pulse.
  always_ff @(posedge mclk or negedge resetG) begin
    if (!resetG) begin
      r_last      <= WW'(N - 1);
      r_win       <= '0;
      r_rw        <= 1'b0;
      r_cnt       <= '0;
      r_eng_addr  <= '0;
      r_eng_reg   <= '0;
      r_eng_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) r_win <= w_pick;
        S_GRANT: begin
          r_rw        <= w_sel_rw;
          r_eng_addr  <= w_sel_addr;
          r_eng_reg   <= w_sel_reg;
          r_eng_wdata <= w_sel_wdata;
          r_last      <= r_win;
          r_cnt       <= '0;
        end
        S_ISSUE: r_cnt <= r_cnt + TW'(1);
        S_WAIT: begin
          r_cnt <= r_cnt + TW'(1);
          if (r_rw && bus.doner) r_rdata <= bus.eng_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.gnt       = bus.busy ? w_win_oh : '0;
  assign bus.ack       = (r_state == S_RESP_OK)  ? w_win_oh : '0;
  assign bus.err       = (r_state == S_RESP_ERR) ? w_win_oh : '0;
  assign bus.StartW    = (r_state == S_ISSUE) && !r_rw;
  assign bus.StartR    = (r_state == S_ISSUE) &&  r_rw;
  assign bus.eng_addr  = r_eng_addr;
  assign bus.eng_reg   = r_eng_reg;
  assign bus.eng_wdata = r_eng_wdata;
  assign bus.rdata     = r_rdata;

endmodule
`default_nettype wire
